// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: FSM states, NOP encoding
// and the default boot address.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pc_register.sv
// Program counter register: loads d when en is high, asynchronous active-high reset to RESET_PC.
module pc_register #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: PC sequencing with jr/jump/branch redirects and the IF/ID register.
// Define FETCH_DELAY_SLOT_EN to keep the instruction fetched alongside a redirect (delay slot).
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  halt,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] ifid_instruction,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
  output logic                  ifid_valid,
  output logic [31:0]           fetch_count,
  output logic                  addr_error
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4, jump_target, raw_target, redirect_target;
  logic                  pc_en, redirect, misaligned;
  logic                  ifid_we, ifid_valid_d, count_inc, err_set;
  logic [DATA_WIDTH-1:0] ifid_instr_d, ifid_pc4_d;

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_next),
    .q     (pc)
  );

  assign Address = (state_q == BOOT) ? RESET_PC : pc;

  // Redirect target selection: jr > jump > branch, low two bits forced to word alignment.
  always_comb begin
    pc_plus4    = pc + DATA_WIDTH'(4);
    jump_target = {pc_plus4[DATA_WIDTH-1:28], jump_index, 2'b00};
    redirect    = jr | jump | branch_taken;
    if (jr) begin
      raw_target = jr_target;
    end else if (jump) begin
      raw_target = jump_target;
    end else begin
      raw_target = branch_target;
    end
    misaligned      = redirect && (raw_target[1:0] != 2'b00);
    redirect_target = {raw_target[DATA_WIDTH-1:2], 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_next      = pc_plus4;
    ifid_we      = 1'b0;
    ifid_instr_d = DATA_WIDTH'(NOP);
    ifid_pc4_d   = '0;
    ifid_valid_d = 1'b0;
    count_inc    = 1'b0;
    err_set      = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
          ifid_we = 1'b1;
        end else begin
          if (redirect) begin
            pc_en   = 1'b1;
            pc_next = redirect_target;
            err_set = misaligned;
          end else if (!stall) begin
            pc_en = 1'b1;
          end

          if (flush) begin
            ifid_we = 1'b1;
          end else if (!stall) begin
            ifid_we = 1'b1;
            if (!redirect || DelaySlot) begin
              ifid_instr_d = Instruction;
              ifid_pc4_d   = pc_plus4;
              ifid_valid_d = 1'b1;
              count_inc    = 1'b1;
            end
          end
        end
      end
      HALTED: begin
        ifid_we = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= BOOT;
      ifid_instruction <= DATA_WIDTH'(NOP);
      ifid_pc_plus4    <= '0;
      ifid_valid       <= 1'b0;
      fetch_count      <= 32'd0;
      addr_error       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ifid_we) begin
        ifid_instruction <= ifid_instr_d;
        ifid_pc_plus4    <= ifid_pc4_d;
        ifid_valid       <= ifid_valid_d;
      end
      if (count_inc) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (err_set) begin
        addr_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a cycle-level behavioural model.
// Honours FETCH_DELAY_SLOT_EN the same way as the design.
module tb_instruction_fetch_unit;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, halt, branch_taken, jump, jr;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] address, instruction, ifid_instruction, ifid_pc_plus4, fetch_count;
  logic        ifid_valid, addr_error;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mode 0 = boot, 1 = run, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_ii, m_ip4, m_cnt;
  logic        m_iv, m_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h0};
  endfunction

  assign instruction = mem(address);

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .halt             (halt),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_index       (jump_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .Address          (address),
    .Instruction      (instruction),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .fetch_count      (fetch_count),
    .addr_error       (addr_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RST_PC; m_ii = 0; m_ip4 = 0; m_iv = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic bubble();
    m_ii = 0; m_ip4 = 0; m_iv = 0;
  endtask

  task automatic model_step();
    logic [31:0] seq, tgt;
    bit          redir;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      bubble();
    end else if (halt) begin
      m_mode = 2;
      bubble();
    end else begin
      seq   = m_pc + 32'd4;
      redir = jr || jump || branch_taken;
      if (jr)        tgt = jr_target;
      else if (jump) tgt = (seq & 32'hF000_0000) | (32'(jump_index) << 2);
      else           tgt = branch_target;
      if (flush) begin
        bubble();
      end else if (!stall) begin
        if (redir && !DS) begin
          bubble();
        end else begin
          m_ii = mem(m_pc); m_ip4 = seq; m_iv = 1; m_cnt = m_cnt + 32'd1;
        end
      end
      if (redir) begin
        if (tgt % 4 != 0) m_err = 1;
        m_pc = tgt - (tgt % 4);
      end else if (!stall) begin
        m_pc = seq;
      end
    end
  endtask

  // Single compare process: advance the model on every edge, check all outputs just after it.
  always @(posedge clk) begin
    if (!reset) model_step();
    #1;
    chk("address", address, (m_mode == 0) ? RST_PC : m_pc);
    chk("ifid_instruction", ifid_instruction, m_ii);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_iv));
    chk("fetch_count", fetch_count, m_cnt);
    chk("addr_error", 32'(addr_error), 32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; halt = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_target = 0; jr_target = 0; jump_index = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    step(); step();
    chk("reset_addr", address, RST_PC);
    chk("reset_count", fetch_count, 32'd0);
    reset = 1'b0;

    // Boot then three idle cycles
    #1;
    chk("boot_addr", address, RST_PC);
    chk("boot_valid", 32'(ifid_valid), 32'd0);
    step();
    chk("idle1_addr", address, 32'h0040_0000);
    chk("idle1_valid", 32'(ifid_valid), 32'd0);
    step();
    chk("idle2_addr", address, 32'h0040_0004);
    chk("idle2_pc4", ifid_pc_plus4, 32'h0040_0004);
    step();
    chk("idle3_addr", address, 32'h0040_0008);
    chk("idle3_count", fetch_count, 32'd2);

    // Jump at PC 0x00400008
    jump = 1; jump_index = 26'h0100010;
    step();
    idle_inputs();
    chk("jump_addr", address, 32'h0040_0040);
    chk("jump_slot_valid", 32'(ifid_valid), 32'(DS));
    chk("jump_slot_pc4", ifid_pc_plus4, DS ? 32'h0040_000C : 32'h0);
    chk("jump_count", fetch_count, DS ? 32'd3 : 32'd2);

    // jr beats branch
    jr = 1; branch_taken = 1; jr_target = 32'h0040_0100; branch_target = 32'h0040_0200;
    step();
    idle_inputs();
    chk("jr_prio_addr", address, 32'h0040_0100);

    // Stall holds PC, then stall with a redirect, then stall with flush
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", address, 32'h0040_0100);
    end
    branch_taken = 1; branch_target = 32'h0040_0200;
    step();
    chk("stall_branch_addr", address, 32'h0040_0200);
    branch_taken = 0; flush = 1;
    step();
    chk("stall_flush_valid", 32'(ifid_valid), 32'd0);
    idle_inputs();
    step();
    chk("after_flush_valid", 32'(ifid_valid), 32'd1);
    chk("after_flush_pc4", ifid_pc_plus4, 32'h0040_0204);

    // Misaligned register target
    jr = 1; jr_target = 32'h0040_0102;
    step();
    idle_inputs();
    chk("misalign_addr", address, 32'h0040_0100);
    chk("misalign_err", 32'(addr_error), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("err_sticky", 32'(addr_error), 32'd1);

    // PC+4 wraps at the top of the address space
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    chk("top_addr", address, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", address, 32'h0000_0000);
    chk("wrap_pc4", ifid_pc_plus4, 32'h0000_0000);

    // Halt beats jump; redirects ignored once halted
    halt = 1; jump = 1; jump_index = 26'h0000040;
    step();
    idle_inputs();
    chk("halt_addr", address, 32'h0000_0000);
    chk("halt_valid", 32'(ifid_valid), 32'd0);
    jr = 1; jr_target = 32'h0040_0300; branch_taken = 1; branch_target = 32'h0040_0400;
    step(); step();
    chk("halted_addr", address, 32'h0000_0000);
    chk("halted_valid", 32'(ifid_valid), 32'd0);

    // Reset pulse with a redirect still asserted
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_addr", address, RST_PC);
    chk("rst_async_err", 32'(addr_error), 32'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    chk("refetch_valid", 32'(ifid_valid), 32'd1);
    chk("refetch_pc4", ifid_pc_plus4, 32'h0040_0004);
    chk("refetch_instr", ifid_instruction, mem(32'h0040_0000));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the PC, address and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, which holds the PC and IF/ID.
REQ-006 SHALL have port flush, input, 1, which loads a bubble into IF/ID.
REQ-007 SHALL have port halt, input, 1, a request to enter HALTED.
REQ-008 SHALL have ports branch_taken, input, 1, and branch_target, input, DATA_WIDTH, for a conditional redirect.
REQ-009 SHALL have ports jump, input, 1, and jump_index, input, 26, for the J/JAL target field.
REQ-010 SHALL have ports jr, input, 1, and jr_target, input, DATA_WIDTH, for the register-indirect target.
REQ-011 SHALL have port Address, output, DATA_WIDTH, the current PC driven to program memory.
REQ-012 SHALL have port Instruction, input, DATA_WIDTH, the combinational read data from program memory.
REQ-013 SHALL have ports ifid_instruction, output, DATA_WIDTH; ifid_pc_plus4, output, DATA_WIDTH; and ifid_valid, output, 1, forming the IF/ID register.
REQ-014 SHALL have ports fetch_count, output, 32, counting valid fetches, and addr_error, output, 1, a sticky misaligned-target flag.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and HALTED.
REQ-016 SHALL transition BOOT->RUN unconditionally after one cycle; BOOT SHALL drive Address=RESET_PC and load no IF/ID entry.
REQ-017 SHALL compute next PC in RUN with priority jr > jump > branch_taken > PC+4.
REQ-018 SHALL form the jump target as {PC+4[31:28], jump_index, 2'b00}.
REQ-019 SHALL let a redirect (jr/jump/branch_taken) update the PC even when stall=1; stall alone SHALL hold the PC.
REQ-020 SHALL force bits [1:0] of a redirect target to 0 when either is nonzero and set addr_error, which stays 1 until reset.
REQ-021 SHALL capture into IF/ID on each RUN cycle with stall=0: Instruction, PC+4 and valid=1.
REQ-022 SHALL hold IF/ID on stall=1 unless flush=1.
REQ-023 SHALL load a bubble (instruction 0, pc_plus4 0, valid 0) on flush=1, overriding stall.
REQ-024 SHALL increment fetch_count (wrap modulo 2^32) only on cycles where IF/ID loads a valid entry.
REQ-025 SHALL, on halt=1 in RUN, freeze the PC, load a bubble and enter HALTED.
REQ-026 SHALL leave HALTED only on reset, holding ifid_valid=0 and ignoring all redirect inputs.
REQ-027 SHALL give halt priority over redirect and stall in the same cycle.
REQ-028 SHALL compute PC+4 modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC wraps to 0.

Reset
REQ-029 SHALL, while reset=1, immediately set the PC to RESET_PC, state to BOOT, ifid_instruction=0, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0 and addr_error=0.
REQ-030 SHALL abandon any redirect or halt in progress when reset asserts mid-operation; the first valid fetch SHALL be RESET_PC.

Configuration
REQ-031 SHALL, with FETCH_DELAY_SLOT_EN defined, capture the instruction fetched in the cycle a redirect is accepted into IF/ID as valid (MIPS delay slot).
REQ-032 SHALL, without FETCH_DELAY_SLOT_EN, load a bubble into IF/ID in that cycle instead, and not count it in fetch_count.

Structure
REQ-033 SHALL take the state enum, NOP value (32'h0) and default RESET_PC from shared package mips_fetch_pkg.
REQ-034 SHALL instantiate one sub-module, pc_register: a DATA_WIDTH register with asynchronous active-high reset to RESET_PC and an enable input.

Verification
REQ-035 SHALL check reset release followed by 3 idle cycles -> Address 0x00400000, 0x00400004, 0x00400008; ifid_valid=0 during BOOT; fetch_count=2.
REQ-036 SHALL check jump=1, jump_index=26'h0100010 at PC 0x00400008 -> next Address=0x00400040; IF/ID holds the delay slot with the macro, a bubble without it.
REQ-037 SHALL check jr=1 and branch_taken=1 together, jr_target=0x00400100, branch_target=0x00400200 -> Address=0x00400100.
REQ-038 SHALL check stall=1 for 3 cycles -> Address and IF/ID unchanged; stall=1 with branch_taken=1 -> PC redirects; stall with flush -> ifid_valid=0.
REQ-039 SHALL check jr_target=0x00400102 -> Address=0x00400100 and addr_error=1, still 1 ten cycles later.
REQ-040 SHALL check halt=1 with jump=1 -> HALTED, PC frozen, ifid_valid=0; then reset pulse -> BOOT and Address=0x00400000.
